// File: rtl/psd_seqdiv.sv
// psd_seqdiv: sequential restoring divider, one quotient bit per clock.
// Fixed latency of NBITS+2 cycles from start to the cycle after done.
// Divisor 0 gives quotient all ones, remainder equal to the dividend, dbz=1.
// Optional build macro PSD_SEQDIV_SIGNED_EN adds two's-complement support
// selected by sgn; without it, sgn is ignored and every division is unsigned.
module psd_seqdiv #(
    parameter int NBITS = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic             sgn,
    input  logic [NBITS-1:0] dividend,
    input  logic [NBITS-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic [NBITS-1:0] quotient,
    output logic [NBITS-1:0] rest
);
    localparam int CW = $clog2(NBITS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [NBITS-1:0] rem_q, rem_d;     // partial remainder
    logic [NBITS-1:0] acc_q, acc_d;     // dividend bits shifting out, quotient bits shifting in
    logic [NBITS-1:0] dvs_q, dvs_d;     // divisor magnitude
    logic             dbzp_q, dbzp_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic [NBITS-1:0] quo_q, quo_d;
    logic [NBITS-1:0] rest_q, rest_d;

    logic [NBITS-1:0] mag_dvd, mag_dvs;
    logic [NBITS-1:0] fix_quo, fix_rest;
    logic [NBITS:0]   trial_min;
    logic [NBITS-1:0] trial_dif;
    logic             trial_ok;

`ifdef PSD_SEQDIV_SIGNED_EN
    logic qneg_q, qneg_d, rneg_q, rneg_d;
    logic dvd_neg, dvs_neg;

    // Operand magnitudes and sign correction of the finished magnitudes
    always_comb begin
        dvd_neg  = sgn & dividend[NBITS-1];
        dvs_neg  = sgn & divisor[NBITS-1];
        mag_dvd  = dvd_neg ? -dividend : dividend;
        mag_dvs  = dvs_neg ? -divisor  : divisor;
        fix_quo  = qneg_q ? -acc_q : acc_q;
        fix_rest = rneg_q ? -rem_q : rem_q;
    end

    // Result sign flags are latched together with the operands
    always_comb begin
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        if (state_q == IDLE && start) begin
            qneg_d = dvd_neg ^ dvs_neg;
            rneg_d = dvd_neg;
        end
    end

    // Sign flag registers
    always_ff @(posedge clock) begin
        if (!resetn) begin
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else begin
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
        end
    end
`else
    logic unused_sgn;
    assign unused_sgn = sgn;

    // Unsigned only: operands and results pass straight through
    always_comb begin
        mag_dvd  = dividend;
        mag_dvs  = divisor;
        fix_quo  = acc_q;
        fix_rest = rem_q;
    end
`endif

    // One restoring step: shift in the next dividend bit, compare, subtract
    always_comb begin
        trial_min = {rem_q, acc_q[NBITS-1]};
        trial_ok  = (trial_min >= {1'b0, dvs_q});
        trial_dif = trial_min[NBITS-1:0] - dvs_q;
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        acc_d   = acc_q;
        dvs_d   = dvs_q;
        dbzp_d  = dbzp_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        quo_d   = quo_q;
        rest_d  = rest_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rem_d   = '0;
                    acc_d   = mag_dvd;
                    dvs_d   = mag_dvs;
                    dbzp_d  = (divisor == '0);
                    cnt_d   = CW'(NBITS);
                    state_d = RUN;
                end
            end
            RUN: begin
                rem_d = trial_ok ? trial_dif : trial_min[NBITS-1:0];
                acc_d = {acc_q[NBITS-2:0], trial_ok};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                // With a zero divisor the remainder window ends up holding the dividend
                quo_d   = dbzp_q ? '1 : fix_quo;
                rest_d  = fix_rest;
                dbz_d   = dbzp_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            acc_q   <= '0;
            dvs_q   <= '0;
            dbzp_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            quo_q   <= '0;
            rest_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            acc_q   <= acc_d;
            dvs_q   <= dvs_d;
            dbzp_q  <= dbzp_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            quo_q   <= quo_d;
            rest_q  <= rest_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign dbz      = dbz_q;
    assign quotient = quo_q;
    assign rest     = rest_q;

endmodule

// File: tb/tb_psd_seqdiv.sv
// Testbench for psd_seqdiv with NBITS=8: directed vectors, hand-computed results.
// Signed vectors are exercised when PSD_SEQDIV_SIGNED_EN is defined; otherwise
// the sgn-ignored behaviour is exercised instead.
module tb_psd_seqdiv;
    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic       sgn = 1'b0;
    logic [7:0] dividend = 8'h00;
    logic [7:0] divisor = 8'h00;
    logic       busy, done, dbz;
    logic [7:0] quotient, rest;

    int errors = 0;
    int checks = 0;

    psd_seqdiv #(.NBITS(8)) dut (
        .clock    (clock),
        .resetn   (resetn),
        .start    (start),
        .sgn      (sgn),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .dbz      (dbz),
        .quotient (quotient),
        .rest     (rest)
    );

    always #5 clock = ~clock;

    // Present operands for one edge, then scramble them so a late capture shows up
    task automatic launch(input logic s, input logic [7:0] a, input logic [7:0] b);
        sgn = s; dividend = a; divisor = b; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; sgn = ~s; dividend = ~a; divisor = ~b;
    endtask

    // Count edges until done is seen (bounded), and cycles with busy high
    task automatic wait_done(output int lat, output int bc);
        lat = 0; bc = 0;
        while (!done && lat < 40) begin
            if (busy) bc++;
            @(posedge clock); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (dbz !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b want 0", dbz); end
        checks++; if (quotient !== 8'h00) begin errors++; $display("FAIL reset_quotient got %h want 00", quotient); end
        checks++; if (rest !== 8'h00) begin errors++; $display("FAIL reset_rest got %h want 00", rest); end
        resetn = 1'b1;
    endtask

    task automatic test_unsigned();
        int lat, bc;
        logic [7:0] q0;
        launch(1'b0, 8'd100, 8'd7);
        wait_done(lat, bc);
        checks++; if (lat !== 9) begin errors++; $display("FAIL u100_7_latency got %0d want 9", lat); end
        checks++; if (bc !== 9) begin errors++; $display("FAIL u100_7_busy_cycles got %0d want 9", bc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL u100_7_busy_with_done got %b want 0", busy); end
        checks++; if (quotient !== 8'h0E) begin errors++; $display("FAIL u100_7_quotient got %h want 0e", quotient); end
        checks++; if (rest !== 8'h02) begin errors++; $display("FAIL u100_7_rest got %h want 02", rest); end
        checks++; if (dbz !== 1'b0) begin errors++; $display("FAIL u100_7_dbz got %b want 0", dbz); end
        q0 = quotient;
        @(posedge clock); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle got %b want 0", done); end
        checks++; if (quotient !== 8'h0E) begin errors++; $display("FAIL quotient_hold got %h want 0e (was %h)", quotient, q0); end
        checks++; if (rest !== 8'h02) begin errors++; $display("FAIL rest_hold got %h want 02", rest); end
        launch(1'b0, 8'd255, 8'd16);
        wait_done(lat, bc);
        checks++; if (quotient !== 8'h0F || rest !== 8'h0F) begin errors++; $display("FAIL u255_16 got q=%h r=%h want q=0f r=0f", quotient, rest); end
        launch(1'b0, 8'd5, 8'd9);
        wait_done(lat, bc);
        checks++; if (quotient !== 8'h00 || rest !== 8'h05) begin errors++; $display("FAIL u5_9 got q=%h r=%h want q=00 r=05", quotient, rest); end
    endtask

`ifdef PSD_SEQDIV_SIGNED_EN
    task automatic test_signed();
        int lat, bc;
        launch(1'b1, 8'h9C, 8'h07);
        wait_done(lat, bc);
        checks++; if (quotient !== 8'hF2 || rest !== 8'hFE) begin errors++; $display("FAIL s_m100_7 got q=%h r=%h want q=f2 r=fe", quotient, rest); end
        checks++; if (lat !== 9) begin errors++; $display("FAIL s_m100_7_latency got %0d want 9", lat); end
        launch(1'b1, 8'h64, 8'hF9);
        wait_done(lat, bc);
        checks++; if (quotient !== 8'hF2 || rest !== 8'h02) begin errors++; $display("FAIL s_100_m7 got q=%h r=%h want q=f2 r=02", quotient, rest); end
        launch(1'b1, 8'h9C, 8'hF9);
        wait_done(lat, bc);
        checks++; if (quotient !== 8'h0E || rest !== 8'hFE) begin errors++; $display("FAIL s_m100_m7 got q=%h r=%h want q=0e r=fe", quotient, rest); end
        launch(1'b1, 8'h80, 8'hFF);
        wait_done(lat, bc);
        checks++; if (quotient !== 8'h80) begin errors++; $display("FAIL s_ovf_quotient got %h want 80", quotient); end
        checks++; if (rest !== 8'h00) begin errors++; $display("FAIL s_ovf_rest got %h want 00", rest); end
        checks++; if (dbz !== 1'b0) begin errors++; $display("FAIL s_ovf_dbz got %b want 0", dbz); end
    endtask
`else
    task automatic test_sgn_ignored();
        int lat, bc;
        launch(1'b1, 8'h9C, 8'h07);
        wait_done(lat, bc);
        checks++; if (quotient !== 8'h16) begin errors++; $display("FAIL nosign_quotient got %h want 16", quotient); end
        checks++; if (rest !== 8'h02) begin errors++; $display("FAIL nosign_rest got %h want 02", rest); end
        checks++; if (lat !== 9) begin errors++; $display("FAIL nosign_latency got %0d want 9", lat); end
    endtask
`endif

    task automatic test_dbz();
        int lat, bc;
        launch(1'b0, 8'd37, 8'd0);
        wait_done(lat, bc);
        checks++; if (quotient !== 8'hFF) begin errors++; $display("FAIL dbz_u_quotient got %h want ff", quotient); end
        checks++; if (rest !== 8'h25) begin errors++; $display("FAIL dbz_u_rest got %h want 25", rest); end
        checks++; if (dbz !== 1'b1) begin errors++; $display("FAIL dbz_u_flag got %b want 1", dbz); end
        checks++; if (lat !== 9) begin errors++; $display("FAIL dbz_u_latency got %0d want 9", lat); end
        launch(1'b1, 8'h9C, 8'h00);
        wait_done(lat, bc);
        checks++; if (quotient !== 8'hFF || rest !== 8'h9C || dbz !== 1'b1) begin errors++; $display("FAIL dbz_s got q=%h r=%h dbz=%b want q=ff r=9c dbz=1", quotient, rest, dbz); end
        launch(1'b0, 8'd20, 8'd4);
        wait_done(lat, bc);
        checks++; if (dbz !== 1'b0 || quotient !== 8'h05 || rest !== 8'h00) begin errors++; $display("FAIL dbz_clear got q=%h r=%h dbz=%b want q=05 r=00 dbz=0", quotient, rest, dbz); end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        launch(1'b0, 8'd200, 8'd3);
        @(posedge clock); #1;
        sgn = 1'b0; dividend = 8'd9; divisor = 8'd2; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        wait_done(lat, bc);
        checks++; if (lat + 2 !== 9) begin errors++; $display("FAIL busy_start_latency got %0d want 9", lat + 2); end
        checks++; if (quotient !== 8'h42 || rest !== 8'h02) begin errors++; $display("FAIL busy_start_result got q=%h r=%h want q=42 r=02", quotient, rest); end
        launch(1'b0, 8'd9, 8'd2);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy=%b want 1", busy); end
        wait_done(lat, bc);
        checks++; if (lat !== 9) begin errors++; $display("FAIL b2b_latency got %0d want 9", lat); end
        checks++; if (quotient !== 8'h04 || rest !== 8'h01) begin errors++; $display("FAIL b2b_result got q=%h r=%h want q=04 r=01", quotient, rest); end
    endtask

    task automatic test_reset_abort();
        int lat, bc;
        launch(1'b0, 8'd50, 8'd5);
        repeat (3) @(posedge clock);
        #1;
        resetn = 1'b0;
        @(posedge clock); #1;
        resetn = 1'b1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_ctrl got busy=%b done=%b want 0 0", busy, done); end
        checks++; if (quotient !== 8'h00 || rest !== 8'h00 || dbz !== 1'b0) begin errors++; $display("FAIL abort_outputs got q=%h r=%h dbz=%b want 00 00 0", quotient, rest, dbz); end
        launch(1'b0, 8'd50, 8'd5);
        wait_done(lat, bc);
        checks++; if (lat !== 9) begin errors++; $display("FAIL abort_restart_latency got %0d want 9", lat); end
        checks++; if (quotient !== 8'h0A || rest !== 8'h00) begin errors++; $display("FAIL abort_restart_result got q=%h r=%h want q=0a r=00", quotient, rest); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
`ifdef PSD_SEQDIV_SIGNED_EN
        test_signed();
`else
        test_sgn_ignored();
`endif
        test_dbz();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
